// File: rtl/cal_abs_angle_if.sv
// rtl/cal_abs_angle_if.sv - sample-in / polar-out bus for cal_abs_angle
interface cal_abs_angle_if;
  logic [7:0]  real_i;
  logic [7:0]  imag_i;
  logic        val_i;
  logic [7:0]  abs_o;
  logic [15:0] angle_o;
  logic        val_o;

  modport master (output real_i, imag_i, val_i, input abs_o, angle_o, val_o);
  modport slave  (input real_i, imag_i, val_i, output abs_o, angle_o, val_o);
endinterface

// File: rtl/cal_abs_angle.sv
// rtl/cal_abs_angle.sv - pipelined complex-to-polar converter (isqrt magnitude, CORDIC phase)
// Optional macro ABS_ROUND_EN: magnitude rounded to nearest instead of floored.
module cal_abs_angle #(
  parameter int ITER = 14,
  parameter int LAT  = ITER + 2
) (
  input  logic           clk,
  input  logic           rst,
  cal_abs_angle_if.slave io
);
  localparam int LAST  = LAT - 2;
  localparam int W     = 32;
  localparam int GUARD = 20;
  localparam int ZW    = 18;
  localparam int SQ_N  = 8;
  localparam logic signed [ZW-1:0] PI_Z  = 18'sd102944;
  localparam logic signed [15:0]   PI_A  = 16'sd25736;
  localparam logic signed [15:0]   HPI_A = 16'sd12868;

  // Angles carry two extra fraction bits (Q3.15) so constant rounding stays below half an output LSB.
  function automatic logic signed [ZW-1:0] atan_z(input int i);
    case (i)
      0:       atan_z = 18'sd25736;
      1:       atan_z = 18'sd15193;
      2:       atan_z = 18'sd8027;
      3:       atan_z = 18'sd4075;
      4:       atan_z = 18'sd2045;
      5:       atan_z = 18'sd1024;
      6:       atan_z = 18'sd512;
      7:       atan_z = 18'sd256;
      8:       atan_z = 18'sd128;
      9:       atan_z = 18'sd64;
      10:      atan_z = 18'sd32;
      11:      atan_z = 18'sd16;
      12:      atan_z = 18'sd8;
      13:      atan_z = 18'sd4;
      14:      atan_z = 18'sd2;
      15:      atan_z = 18'sd1;
      default: atan_z = 18'sd0;
    endcase
  endfunction

  logic signed [8:0]    re_s, im_s, x_in, y_in;
  logic signed [17:0]   re_w, im_w, re_sq, im_sq;
  logic [15:0]          sum_in;
  logic signed [ZW-1:0] z_in;
  logic                 sp_in;
  logic signed [15:0]   spa_in;

  // Widen before negating so -128 maps to +128 cleanly.
  always_comb begin
    re_s   = {io.real_i[7], io.real_i};
    im_s   = {io.imag_i[7], io.imag_i};
    x_in   = re_s[8] ? -re_s : re_s;
    y_in   = re_s[8] ? -im_s : im_s;
    z_in   = '0;
    if (re_s[8]) z_in = im_s[8] ? -PI_Z : PI_Z;
    re_w   = 18'(re_s);
    im_w   = 18'(im_s);
    re_sq  = re_w * re_w;
    im_sq  = im_w * im_w;
    sum_in = 16'(re_sq + im_sq);
    sp_in  = (re_s == 9'sd0) || (im_s == 9'sd0);
    spa_in = '0;
    if (im_s == 9'sd0)      spa_in = re_s[8] ? PI_A : 16'sd0;
    else if (re_s == 9'sd0) spa_in = im_s[8] ? -HPI_A : HPI_A;
  end

  logic [ITER:0]        v_q;
  logic signed [W-1:0]  x_q   [0:ITER];
  logic signed [W-1:0]  y_q   [0:ITER];
  logic signed [ZW-1:0] z_q   [0:ITER];
  logic [15:0]          rad_q [0:ITER];
  logic [7:0]           sq_q  [0:ITER];
  logic signed [12:0]   sr_q  [0:ITER];
  logic                 sp_q  [0:ITER];
  logic signed [15:0]   spa_q [0:ITER];

  logic signed [W-1:0]  x_n  [1:ITER];
  logic signed [W-1:0]  y_n  [1:ITER];
  logic signed [ZW-1:0] z_n  [1:ITER];
  logic [7:0]           sq_n [1:ITER];
  logic signed [12:0]   sr_n [1:ITER];
  logic signed [12:0]   r_sh, r_nx;

  // Stage j runs CORDIC step j-1; the first SQ_N stages also resolve one sqrt bit each (non-restoring).
  always_comb begin
    r_sh = '0;
    r_nx = '0;
    for (int j = 1; j <= ITER; j++) begin
      if (!y_q[j-1][W-1]) begin
        x_n[j] = x_q[j-1] + (y_q[j-1] >>> (j - 1));
        y_n[j] = y_q[j-1] - (x_q[j-1] >>> (j - 1));
        z_n[j] = z_q[j-1] + atan_z(j - 1);
      end else begin
        x_n[j] = x_q[j-1] - (y_q[j-1] >>> (j - 1));
        y_n[j] = y_q[j-1] + (x_q[j-1] >>> (j - 1));
        z_n[j] = z_q[j-1] - atan_z(j - 1);
      end
      sq_n[j] = sq_q[j-1];
      sr_n[j] = sr_q[j-1];
      if (j <= SQ_N) begin
        r_sh = {sr_q[j-1][10:0], rad_q[j-1][2*(SQ_N-j) +: 2]};
        if (!sr_q[j-1][12]) r_nx = r_sh - $signed({3'b000, sq_q[j-1], 2'b01});
        else                r_nx = r_sh + $signed({3'b000, sq_q[j-1], 2'b11});
        sr_n[j] = r_nx;
        sq_n[j] = {sq_q[j-1][6:0], ~r_nx[12]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= {v_q[ITER-1:0], io.val_i};
  end

  // Operands carry GUARD fraction bits so truncation in the shifts stays far below one output LSB.
  always_ff @(posedge clk) begin
    x_q[0]   <= {{(W-9-GUARD){x_in[8]}}, x_in, {GUARD{1'b0}}};
    y_q[0]   <= {{(W-9-GUARD){y_in[8]}}, y_in, {GUARD{1'b0}}};
    z_q[0]   <= z_in;
    rad_q[0] <= sum_in;
    sq_q[0]  <= '0;
    sr_q[0]  <= '0;
    sp_q[0]  <= sp_in;
    spa_q[0] <= spa_in;
    for (int j = 1; j <= ITER; j++) begin
      x_q[j]   <= x_n[j];
      y_q[j]   <= y_n[j];
      z_q[j]   <= z_n[j];
      rad_q[j] <= rad_q[j-1];
      sq_q[j]  <= sq_n[j];
      sr_q[j]  <= sr_n[j];
      sp_q[j]  <= sp_q[j-1];
      spa_q[j] <= spa_q[j-1];
    end
  end

  logic signed [ZW:0]   z_ext, z_rnd;
  logic signed [16:0]   ang_w;
  logic signed [15:0]   ang_n;
  logic [7:0]           abs_n;
`ifdef ABS_ROUND_EN
  logic signed [12:0]   rem;
`endif

  // Final y sign says which side of z the residual angle lies: bias by half an LSB before rounding.
  always_comb begin
    z_ext = {z_q[LAST][ZW-1], z_q[LAST]};
    if (y_q[LAST][W-1])       z_rnd = z_ext;
    else if (y_q[LAST] != 0)  z_rnd = z_ext + 19'sd4;
    else                      z_rnd = z_ext + 19'sd2;
    ang_w = 17'(z_rnd >>> 2);
    if (ang_w > 17'sd25736)       ang_n = PI_A;
    else if (ang_w < -17'sd25736) ang_n = -PI_A;
    else                          ang_n = ang_w[15:0];
    if (sp_q[LAST]) ang_n = spa_q[LAST];
`ifdef ABS_ROUND_EN
    rem   = sr_q[LAST][12] ? sr_q[LAST] + $signed({4'b0000, sq_q[LAST], 1'b1}) : sr_q[LAST];
    abs_n = sq_q[LAST] + {7'd0, (rem > $signed({5'b00000, sq_q[LAST]}))};
`else
    abs_n = sq_q[LAST];
`endif
  end

  logic [7:0]  abs_q;
  logic [15:0] ang_q;
  logic        val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      abs_q <= '0;
      ang_q <= '0;
      val_q <= 1'b0;
    end else begin
      val_q <= v_q[LAST];
      if (v_q[LAST]) begin
        abs_q <= abs_n;
        ang_q <= ang_n;
      end
    end
  end

  assign io.abs_o   = abs_q;
  assign io.angle_o = ang_q;
  assign io.val_o   = val_q;
endmodule

// File: tb/tb_cal_abs_angle.sv
// tb/tb_cal_abs_angle.sv - self-checking bench for cal_abs_angle
module tb_cal_abs_angle;
  localparam int LAT = 16;
  localparam int HN  = 4096;

  typedef struct {
    int re;
    int im;
    int abs_e;
    int ang_e;
    int tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  cal_abs_angle_if bus();
  cal_abs_angle dut (.clk(clk), .rst(rst), .io(bus));
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic h_v   [HN];
  int   h_abs [HN];
  int   h_ang [HN];
  int   h_tol [HN];
  int   held_abs, held_ang, held_tol;
  vec_t tbl [11];

  function automatic int ref_abs(int re, int im);
    int s = re * re + im * im;
    int q = 0;
    while ((q + 1) * (q + 1) <= s) q++;
`ifdef ABS_ROUND_EN
    if (s - q * q > q) q++;
`endif
    return q;
  endfunction

  function automatic int ref_ang(int re, int im);
    real a = $atan2($itor(im), $itor(re)) * 8192.0;
    return (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
  endfunction

  // One clock: apply inputs, record what should emerge LAT cycles later, then check outputs.
  task automatic tick(input logic r, input logic v, input int re, input int im,
                      input int ea, input int eg, input int tol);
    logic exp_v;
    int   d;
    rst         = r;
    bus.val_i   = v;
    bus.real_i  = 8'(re);
    bus.imag_i  = 8'(im);
    h_v[cyc]    = v & ~r;
    h_abs[cyc]  = ea;
    h_ang[cyc]  = eg;
    h_tol[cyc]  = tol;
    if (r) for (int k = 0; k < cyc; k++) h_v[k] = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = 1'b0;
    if (r) begin
      held_abs = 0; held_ang = 0; held_tol = 0;
    end else if (cyc >= LAT && h_v[cyc-LAT]) begin
      exp_v    = 1'b1;
      held_abs = h_abs[cyc-LAT];
      held_ang = h_ang[cyc-LAT];
      held_tol = h_tol[cyc-LAT];
    end
    n_vec++;
    if (bus.val_o !== exp_v) begin
      n_err++;
      $display("FAIL val_o cycle %0d: got %b expected %b", cyc, bus.val_o, exp_v);
    end
    if (int'(bus.abs_o) != held_abs) begin
      n_err++;
      $display("FAIL abs_o cycle %0d: got %0d expected %0d", cyc, bus.abs_o, held_abs);
    end
    d = int'($signed(bus.angle_o)) - held_ang;
    if (d < 0) d = -d;
    if (d > held_tol) begin
      n_err++;
      $display("FAIL angle_o cycle %0d: got %0d expected %0d (+/-%0d)",
               cyc, $signed(bus.angle_o), held_ang, held_tol);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_sample(input logic r);
    int re, im;
    re = int'($urandom_range(0, 255)) - 128;
    im = int'($urandom_range(0, 255)) - 128;
    tick(r, 1'b1, re, im, ref_abs(re, im), ref_ang(re, im), (re == 0 || im == 0) ? 0 : 1);
  endtask

  initial begin
    for (int k = 0; k < HN; k++) h_v[k] = 1'b0;
    held_abs = 0; held_ang = 0; held_tol = 0;
    bus.val_i = 1'b0; bus.real_i = '0; bus.imag_i = '0;

    tbl[0]  = '{3, 4, 5, 7596, 1};
    tbl[1]  = '{-128, 0, 128, 25736, 0};
    tbl[2]  = '{0, -128, 128, -12868, 0};
    tbl[3]  = '{-128, -128, 181, -19302, 1};
    tbl[4]  = '{0, 0, 0, 0, 0};
`ifdef ABS_ROUND_EN
    tbl[5]  = '{127, 127, 180, 6434, 1};
`else
    tbl[5]  = '{127, 127, 179, 6434, 1};
`endif
    tbl[6]  = '{1, 1, 1, 6434, 1};
    tbl[7]  = '{-1, 0, 1, 25736, 0};
    tbl[8]  = '{0, 7, 7, 12868, 0};
    tbl[9]  = '{-3, -4, 5, -18140, 1};
    tbl[10] = '{12, 5, 13, 3234, 1};

    repeat (3) tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    idle(2);

    foreach (tbl[k]) tick(1'b0, 1'b1, tbl[k].re, tbl[k].im, tbl[k].abs_e, tbl[k].ang_e, tbl[k].tol);
    idle(LAT + 4);

    // Isolated sample: val_o must rise exactly LAT cycles later and fall after one cycle.
    tick(1'b0, 1'b1, 3, 4, 5, 7596, 1);
    idle(LAT + 3);

    // Bubble pattern 1,0,0,1: outputs hold through the gap.
    tick(1'b0, 1'b1, 10, 20, ref_abs(10, 20), ref_ang(10, 20), 1);
    idle(2);
    tick(1'b0, 1'b1, -50, 33, ref_abs(-50, 33), ref_ang(-50, 33), 1);
    idle(LAT + 3);

    repeat (1024) rnd_sample(1'b0);
    idle(LAT + 3);

    // Reset for one cycle mid-stream: nothing issued before or during it may emerge.
    repeat (30) rnd_sample(1'b0);
    rnd_sample(1'b1);
    repeat (10) rnd_sample(1'b0);
    idle(LAT + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
